// File: rtl/pc_ras_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : pc_ras_unit                                           |
// | Desc     : Y86 next-PC register with circular return-addr stack  |
// |            Optional MISS_CNT output under `RAS_MISS_CNT_EN       |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module pc_ras_unit #(
  parameter int                 WIDTH     = 32,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VEC = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             STALL,
  input  logic             VALID,
  input  logic [3:0]       icode,
  input  logic             Cnd,
  input  logic [WIDTH-1:0] valC,
  input  logic [WIDTH-1:0] valM,
  input  logic [WIDTH-1:0] valP,
  output logic [WIDTH-1:0] NEW_PC,
  output logic [WIDTH-1:0] RAS_TOP,
  output logic             RAS_VALID,
  output logic             RAS_OVF,
  output logic             RAS_UNF,
  output logic             RAS_MISS
`ifdef RAS_MISS_CNT_EN
  ,
  output logic [15:0]      MISS_CNT
`endif
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam int              c_CW   = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
  localparam logic [3:0]      c_JXX  = 4'h7;
  localparam logic [3:0]      c_CALL = 4'h8;
  localparam logic [3:0]      c_RET  = 4'h9;

  logic [WIDTH-1:0] r_pc;
  logic [c_AW-1:0]  r_sp;
  logic [c_CW-1:0]  r_cnt;
  logic             r_ovf;
  logic             r_unf;
  logic             r_miss;
  logic [WIDTH-1:0] r_entry [DEPTH];

  logic             w_upd;
  logic             w_empty;
  logic             w_full;
  logic [c_AW-1:0]  w_sp_dec;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_seq_pc;
  logic [WIDTH-1:0] w_pc_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_miss_nxt;
  logic             w_unf_set;

  assign w_upd    = RST_N && !STALL && VALID;
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == c_FULL);
  assign w_sp_dec = r_sp - c_AW'(1);
  assign w_top    = r_entry[w_sp_dec];
  assign w_seq_pc = r_pc + valP;

  always_comb begin
    w_pc_nxt   = w_seq_pc;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_miss_nxt = 1'b0;
    w_unf_set  = 1'b0;
    if (icode == c_CALL) begin
      w_pc_nxt = valC;
      w_push   = w_upd;
    end else if (icode == c_JXX && Cnd) begin
      w_pc_nxt = valC;
    end else if (icode == c_RET) begin
      // valM is the architectural target; the stack only predicts it
      w_pc_nxt = valM;
      if (!w_empty) begin
        w_pop      = w_upd;
        w_miss_nxt = w_upd && (w_top != valM);
      end else begin
        w_unf_set  = w_upd;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_pc   <= RESET_VEC;
      r_sp   <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_miss <= 1'b0;
    end else begin
      r_miss <= w_miss_nxt;
      if (w_upd) begin
        r_pc <= w_pc_nxt;
        if (w_unf_set) begin
          r_unf <= 1'b1;
        end
        if (w_push) begin
          // when full, sp already points at the oldest entry, so it is overwritten
          r_sp <= r_sp + c_AW'(1);
          if (w_full) begin
            r_ovf <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end else if (w_pop) begin
          r_sp  <= w_sp_dec;
          r_cnt <= r_cnt - c_CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_entry[r_sp] <= w_seq_pc;
    end
  end

`ifdef RAS_MISS_CNT_EN
  logic [15:0] r_miss_cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_miss_cnt <= '0;
    end else if (w_miss_nxt && r_miss_cnt != 16'hFFFF) begin
      r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign MISS_CNT = r_miss_cnt;
`endif

  assign NEW_PC    = r_pc;
  assign RAS_TOP   = w_empty ? '0 : w_top;
  assign RAS_VALID = !w_empty;
  assign RAS_OVF   = r_ovf;
  assign RAS_UNF   = r_unf;
  assign RAS_MISS  = r_miss;

endmodule
`default_nettype wire

// File: tb/tb_pc_ras_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_pc_ras_unit                                        |
// | Desc     : Directed vector table plus randomized model checking  |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_pc_ras_unit;

  localparam int          c_W  = 32;
  localparam int          c_D  = 4;
  localparam logic [31:0] c_RV = 32'h100;

  logic        CLK = 1'b0;
  logic        RST_N, STALL, VALID, Cnd;
  logic [3:0]  icode;
  logic [31:0] valC, valM, valP;
  logic [31:0] NEW_PC, RAS_TOP;
  logic        RAS_VALID, RAS_OVF, RAS_UNF, RAS_MISS;
`ifdef RAS_MISS_CNT_EN
  logic [15:0] MISS_CNT;
`endif

  pc_ras_unit #(.WIDTH(c_W), .DEPTH(c_D), .RESET_VEC(c_RV)) dut (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .VALID(VALID),
    .icode(icode), .Cnd(Cnd), .valC(valC), .valM(valM), .valP(valP),
    .NEW_PC(NEW_PC), .RAS_TOP(RAS_TOP), .RAS_VALID(RAS_VALID),
    .RAS_OVF(RAS_OVF), .RAS_UNF(RAS_UNF), .RAS_MISS(RAS_MISS)
`ifdef RAS_MISS_CNT_EN
    , .MISS_CNT(MISS_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst_n, stall, valid, cnd;
    logic [3:0]  ic;
    logic [31:0] vc, vm, vp;
    logic [31:0] e_pc, e_top;
    logic        e_v, e_ovf, e_unf, e_miss;
    int          e_mc;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: PC plus a bounded list of return addresses (newest last)
  logic [31:0] m_pc;
  logic [31:0] m_stk[$];
  logic        m_ovf, m_unf, m_miss;
  int          m_mc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, s, v, input logic [3:0] ic, input logic c,
                     input logic [31:0] vc, vm, vp, epc, etop,
                     input logic ev, eovf, eunf, emiss, input int emc);
    vec_t t;
    t.rst_n = r; t.stall = s; t.valid = v; t.ic = ic; t.cnd = c;
    t.vc = vc; t.vm = vm; t.vp = vp; t.e_pc = epc; t.e_top = etop;
    t.e_v = ev; t.e_ovf = eovf; t.e_unf = eunf; t.e_miss = emiss; t.e_mc = emc;
    vecs.push_back(t);
  endtask

  task automatic model_step(input vec_t t);
    logic [31:0] popped;
    if (!t.rst_n) begin
      m_pc = c_RV; m_stk.delete(); m_ovf = 0; m_unf = 0; m_miss = 0; m_mc = 0;
    end else if (!t.stall && t.valid) begin
      m_miss = 0;
      if (t.ic == 4'd8) begin
        m_stk.push_back(m_pc + t.vp);
        if (m_stk.size() > c_D) begin
          void'(m_stk.pop_front());
          m_ovf = 1;
        end
        m_pc = t.vc;
      end else if (t.ic == 4'd7 && t.cnd) begin
        m_pc = t.vc;
      end else if (t.ic == 4'd9) begin
        if (m_stk.size() > 0) begin
          popped = m_stk.pop_back();
          m_miss = (popped != t.vm);
          if (m_miss && m_mc < 65535) m_mc++;
        end else begin
          m_unf = 1;
        end
        m_pc = t.vm;
      end else begin
        m_pc = m_pc + t.vp;
      end
    end else begin
      m_miss = 0;
    end
  endtask

  task automatic apply(input vec_t t);
    RST_N = t.rst_n; STALL = t.stall; VALID = t.valid; icode = t.ic;
    Cnd = t.cnd; valC = t.vc; valM = t.vm; valP = t.vp;
    model_step(t);
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] m_top();
    return (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 32'h0;
  endfunction

  initial begin
    vec_t t;
    //  rst st vl ic cnd valC          valM   valP  exp_pc        exp_top v ovf unf miss mcnt
    add(0, 0, 0, 0, 0, 0,            0,     0,    32'h100,      0,      0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0,            0,     2,    32'h102,      0,      0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0,            0,     2,    32'h104,      0,      0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0,            0,     2,    32'h106,      0,      0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,            0,     0,    32'h100,      0,      0, 0, 0, 0, 0);
    add(1, 0, 1, 8, 0, 32'h200,      0,     9,    32'h200,      32'h109, 1, 0, 0, 0, 0);
    add(1, 0, 1, 9, 0, 0,            32'h109, 0,  32'h109,      0,      0, 0, 0, 0, 0);
    add(1, 0, 1, 7, 1, 32'h300,      0,     9,    32'h300,      0,      0, 0, 0, 0, 0);
    add(1, 0, 1, 7, 0, 32'h300,      0,     9,    32'h309,      0,      0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,            0,     0,    32'h100,      0,      0, 0, 0, 0, 0);
    add(1, 0, 1, 8, 0, 32'h200,      0,     9,    32'h200,      32'h109, 1, 0, 0, 0, 0);
    add(1, 0, 1, 9, 0, 0,            32'h777, 0,  32'h777,      0,      0, 0, 0, 1, 1);
    add(1, 0, 0, 9, 0, 0,            32'h777, 0,  32'h777,      0,      0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,            0,     0,    32'h100,      0,      0, 0, 0, 0, 0);
    add(1, 0, 1, 8, 0, 32'h200,      0,     9,    32'h200,      32'h109, 1, 0, 0, 0, 0);
    add(1, 1, 1, 8, 0, 32'h400,      0,     5,    32'h200,      32'h109, 1, 0, 0, 0, 0);
    add(1, 0, 0, 8, 0, 32'h400,      0,     5,    32'h200,      32'h109, 1, 0, 0, 0, 0);
    add(1, 0, 1, 7, 1, 32'hFFFFFFFE, 0,     0,    32'hFFFFFFFE, 32'h109, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0,            0,     4,    32'h2,        32'h109, 1, 0, 0, 0, 0);
    add(0, 1, 1, 8, 0, 32'h400,      0,     5,    32'h100,      0,      0, 0, 0, 0, 0);
    add(1, 0, 1, 8, 0, 32'h200,      0,     9,    32'h200,      32'h109, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 0, 1, 8, 0, 32'h200,    0,     9,    32'h200,      32'h209, 1, 0, 0, 0, 0);
    add(1, 0, 1, 8, 0, 32'h200,      0,     9,    32'h200,      32'h209, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 0, 1, 9, 0, 0,          32'h209, 0,  32'h209,      32'h209, 1, 1, 0, 0, 0);
    add(1, 0, 1, 9, 0, 0,            32'h209, 0,  32'h209,      0,      0, 1, 0, 0, 0);
    add(1, 0, 1, 9, 0, 0,            32'h50, 0,   32'h50,       0,      0, 1, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0,            0,     4,    32'h54,       0,      0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,            0,     0,    32'h100,      0,      0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i]);
      chk($sformatf("vec%0d_pc", i),   NEW_PC,    vecs[i].e_pc);
      chk($sformatf("vec%0d_top", i),  RAS_TOP,   vecs[i].e_top);
      chk($sformatf("vec%0d_vld", i),  {31'b0, RAS_VALID}, {31'b0, vecs[i].e_v});
      chk($sformatf("vec%0d_ovf", i),  {31'b0, RAS_OVF},   {31'b0, vecs[i].e_ovf});
      chk($sformatf("vec%0d_unf", i),  {31'b0, RAS_UNF},   {31'b0, vecs[i].e_unf});
      chk($sformatf("vec%0d_miss", i), {31'b0, RAS_MISS},  {31'b0, vecs[i].e_miss});
`ifdef RAS_MISS_CNT_EN
      chk($sformatf("vec%0d_mcnt", i), {16'b0, MISS_CNT},  vecs[i].e_mc);
`endif
    end

    for (int n = 0; n < 600; n++) begin
      int sel;
      t.rst_n = ($urandom_range(0, 99) >= 2);
      t.stall = ($urandom_range(0, 9) == 0);
      t.valid = ($urandom_range(0, 7) != 0);
      sel     = $urandom_range(0, 6);
      t.ic    = (sel == 0) ? 4'd8 : (sel == 1 || sel == 2) ? 4'd9 :
                (sel == 3) ? 4'd7 : 4'($urandom_range(0, 15));
      t.cnd   = 1'($urandom_range(0, 1));
      t.vc    = $urandom;
      t.vp    = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(1, 10));
      t.vm    = ($urandom_range(0, 2) != 0) ? m_top() : $urandom;
      apply(t);
      chk($sformatf("rnd%0d_pc", n),   NEW_PC,  m_pc);
      chk($sformatf("rnd%0d_top", n),  RAS_TOP, m_top());
      chk($sformatf("rnd%0d_vld", n),  {31'b0, RAS_VALID}, {31'b0, (m_stk.size() != 0)});
      chk($sformatf("rnd%0d_ovf", n),  {31'b0, RAS_OVF},   {31'b0, m_ovf});
      chk($sformatf("rnd%0d_unf", n),  {31'b0, RAS_UNF},   {31'b0, m_unf});
      chk($sformatf("rnd%0d_miss", n), {31'b0, RAS_MISS},  {31'b0, m_miss});
`ifdef RAS_MISS_CNT_EN
      chk($sformatf("rnd%0d_mcnt", n), {16'b0, MISS_CNT},  m_mc);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
